// File: rtl/pmp_region_encoder.sv
// Encodes a base/size/mode region request into pmpaddr/mode entry writes for the
// PMP entry register file. Each request ends with a one-cycle completion response.
package riscv;
  typedef enum logic [1:0] {
    OFF   = 2'b00,
    TOR   = 2'b01,
    NA4   = 2'b10,
    NAPOT = 2'b11
  } pmp_addr_mode_t;
endpackage

module pmp_region_encoder #(
  parameter int unsigned PLEN           = 56,
  parameter int unsigned PMP_LEN        = 54,
  parameter int unsigned PMPGranularity = 0,
  parameter int unsigned NUM_ENTRIES    = 16,
  localparam int unsigned IDX_W         = $clog2(NUM_ENTRIES)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [PLEN-1:0]       req_base_i,
  input  logic [PLEN-1:0]       req_size_i,
  input  riscv::pmp_addr_mode_t req_mode_i,
  input  logic [IDX_W-1:0]      req_idx_i,
  output logic                  wr_valid_o,
  input  logic                  wr_ready_i,
  output logic [IDX_W-1:0]      wr_idx_o,
  output logic [PMP_LEN-1:0]    wr_addr_o,
  output riscv::pmp_addr_mode_t wr_mode_o,
  output logic                  rsp_valid_o,
  output logic                  rsp_err_o
);
  import riscv::*;

  localparam int unsigned S = 2 + PMPGranularity;
  localparam logic [PLEN-1:0] GRAIN_MASK = PLEN'((64'd1 << S) - 64'd1);
  localparam logic [PLEN-1:0] NAPOT_MIN  = PLEN'(64'd1 << (S + 1));
  localparam logic [PLEN:0]   ADDR_SPACE = {1'b1, {PLEN{1'b0}}};

  typedef enum logic [2:0] {IDLE, CHECK, WR0, WR1, RSP} state_t;

  state_t state_q, state_d;

  logic [PLEN-1:0]  base_q, size_q;
  pmp_addr_mode_t   mode_q;
  logic [IDX_W-1:0] idx_q;

  logic               err_q, tor_q;
  logic [IDX_W-1:0]   idx0_q;
  logic [PMP_LEN-1:0] addr0_q, addr1_q;
  pmp_addr_mode_t     mode0_q;

  logic [PLEN:0]      end_c, end_sh_c;
  logic [PLEN-1:0]    napot_c;
  logic               in_space_c, size_pow2_c, idx_ok_c, legal_c;
  logic [IDX_W-1:0]   idx0_c;
  logic [PMP_LEN-1:0] addr0_c;
  pmp_addr_mode_t     mode0_c;

  // Sums are one bit wider than PLEN so a region ending exactly at the top of the
  // address space is representable and can be range-checked before truncation.
  always_comb begin
    end_c       = {1'b0, base_q} + {1'b0, size_q};
    end_sh_c    = end_c >> S;
    in_space_c  = (end_c <= ADDR_SPACE);
    size_pow2_c = (size_q != '0) && ((size_q & (size_q - 1'b1)) == '0);
    idx_ok_c    = (32'(idx_q) < NUM_ENTRIES);
    napot_c     = (base_q >> S) | ((size_q >> (S + 1)) - 1'b1);
    legal_c     = 1'b0;
    idx0_c      = idx_q;
    addr0_c     = '0;
    mode0_c     = OFF;
    case (mode_q)
      OFF: legal_c = 1'b1;
      NA4: begin
        legal_c = (PMPGranularity == 0) && (size_q == PLEN'(4)) && (base_q[1:0] == 2'b00);
        addr0_c = PMP_LEN'(base_q >> 2);
        mode0_c = NA4;
      end
      NAPOT: begin
        legal_c = size_pow2_c && (size_q >= NAPOT_MIN) &&
                  ((base_q & (size_q - 1'b1)) == '0) && in_space_c;
        addr0_c = PMP_LEN'(napot_c);
        mode0_c = NAPOT;
      end
      TOR: begin
        legal_c = (idx_q != '0) && (size_q != '0) &&
                  ((base_q & GRAIN_MASK) == '0) && ((size_q & GRAIN_MASK) == '0) &&
                  in_space_c && ((end_sh_c >> PMP_LEN) == '0);
        idx0_c  = idx_q - 1'b1;
        addr0_c = PMP_LEN'(base_q >> S);
        mode0_c = OFF;
      end
      default: legal_c = 1'b0;
    endcase
    legal_c = legal_c && idx_ok_c;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      base_q  <= '0;
      size_q  <= '0;
      mode_q  <= OFF;
      idx_q   <= '0;
      err_q   <= 1'b0;
      tor_q   <= 1'b0;
      idx0_q  <= '0;
      addr0_q <= '0;
      addr1_q <= '0;
      mode0_q <= OFF;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && req_valid_i) begin
        base_q <= req_base_i;
        size_q <= req_size_i;
        mode_q <= req_mode_i;
        idx_q  <= req_idx_i;
      end
      if (state_q == CHECK) begin
        err_q   <= !legal_c;
        tor_q   <= (mode_q == TOR);
        idx0_q  <= idx0_c;
        addr0_q <= addr0_c;
        addr1_q <= PMP_LEN'(end_sh_c);
        mode0_q <= mode0_c;
      end
    end
  end

  // Outputs decode from registered state only, so wr_ready_i never reaches wr_valid_o.
  always_comb begin
    state_d     = state_q;
    req_ready_o = 1'b0;
    wr_valid_o  = 1'b0;
    wr_idx_o    = '0;
    wr_addr_o   = '0;
    wr_mode_o   = OFF;
    rsp_valid_o = 1'b0;
    rsp_err_o   = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) state_d = CHECK;
      end
      CHECK: state_d = legal_c ? WR0 : RSP;
      WR0: begin
        wr_valid_o = 1'b1;
        wr_idx_o   = idx0_q;
        wr_addr_o  = addr0_q;
        wr_mode_o  = mode0_q;
        if (wr_ready_i) state_d = tor_q ? WR1 : RSP;
      end
      WR1: begin
        wr_valid_o = 1'b1;
        wr_idx_o   = idx_q;
        wr_addr_o  = addr1_q;
        wr_mode_o  = TOR;
        if (wr_ready_i) state_d = RSP;
      end
      RSP: begin
        rsp_valid_o = 1'b1;
        rsp_err_o   = err_q;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_pmp_region_encoder.sv
// Directed bench for pmp_region_encoder: default instance plus a G=1, 12-entry
// instance that exercises grain-dependent and index-range rejections.
`timescale 1ns/1ps
module tb_pmp_region_encoder;
  import riscv::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  logic           req_valid, req_ready, wr_valid, wr_ready, rsp_valid, rsp_err;
  logic [55:0]    req_base, req_size;
  pmp_addr_mode_t req_mode, wr_mode;
  logic [3:0]     req_idx, wr_idx;
  logic [53:0]    wr_addr;

  logic           g_req_valid, g_req_ready, g_wr_valid, g_wr_ready, g_rsp_valid, g_rsp_err;
  logic [55:0]    g_req_base, g_req_size;
  pmp_addr_mode_t g_req_mode, g_wr_mode;
  logic [3:0]     g_req_idx, g_wr_idx;
  logic [53:0]    g_wr_addr;

  pmp_region_encoder dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_base_i(req_base), .req_size_i(req_size), .req_mode_i(req_mode), .req_idx_i(req_idx),
    .wr_valid_o(wr_valid), .wr_ready_i(wr_ready), .wr_idx_o(wr_idx),
    .wr_addr_o(wr_addr), .wr_mode_o(wr_mode),
    .rsp_valid_o(rsp_valid), .rsp_err_o(rsp_err)
  );

  pmp_region_encoder #(.PMPGranularity(1), .NUM_ENTRIES(12)) dut_g1 (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(g_req_valid), .req_ready_o(g_req_ready),
    .req_base_i(g_req_base), .req_size_i(g_req_size), .req_mode_i(g_req_mode), .req_idx_i(g_req_idx),
    .wr_valid_o(g_wr_valid), .wr_ready_i(g_wr_ready), .wr_idx_o(g_wr_idx),
    .wr_addr_o(g_wr_addr), .wr_mode_o(g_wr_mode),
    .rsp_valid_o(g_rsp_valid), .rsp_err_o(g_rsp_err)
  );

  typedef struct {
    string       tag;
    bit          is_rsp;
    logic [3:0]  idx;
    logic [53:0] addr;
    logic [1:0]  mode;
    bit          err;
    int          cyc;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic peekExp(input bit sel, output int n, output exp_t e);
    if (sel) begin
      n = q1.size();
      if (n != 0) e = q1[0];
    end else begin
      n = q0.size();
      if (n != 0) e = q0[0];
    end
  endtask

  task automatic pushExp(input bit sel, input exp_t e);
    if (sel) q1.push_back(e);
    else q0.push_back(e);
  endtask

  task automatic popExp(input bit sel);
    if (sel) void'(q1.pop_front());
    else void'(q0.pop_front());
  endtask

  // Scoreboard side: every write handshake and response pulse must match the queue head.
  task automatic monitorStep(input bit sel);
    logic wv, wrdy, rv, re;
    logic [3:0] wi;
    logic [53:0] wa;
    logic [1:0] wm;
    exp_t e;
    int n;
    wv   = sel ? g_wr_valid  : wr_valid;
    wrdy = sel ? g_wr_ready  : wr_ready;
    rv   = sel ? g_rsp_valid : rsp_valid;
    re   = sel ? g_rsp_err   : rsp_err;
    wi   = sel ? g_wr_idx    : wr_idx;
    wa   = sel ? g_wr_addr   : wr_addr;
    wm   = sel ? g_wr_mode   : wr_mode;
    if (wv && wrdy) begin
      peekExp(sel, n, e);
      if (n == 0 || e.is_rsp) checkOutput(sel ? "g1_unexpected_write" : "unexpected_write", 64'(wv), 64'd0);
      else begin
        popExp(sel);
        checkOutput({e.tag, "_wr_idx"}, 64'(wi), 64'(e.idx));
        checkOutput({e.tag, "_wr_addr"}, 64'(wa), 64'(e.addr));
        checkOutput({e.tag, "_wr_mode"}, 64'(wm), 64'(e.mode));
        if (e.cyc >= 0) checkOutput({e.tag, "_wr_cycle"}, 64'(cyc), 64'(e.cyc));
      end
    end
    if (rv) begin
      peekExp(sel, n, e);
      if (n == 0 || !e.is_rsp) checkOutput(sel ? "g1_unexpected_rsp" : "unexpected_rsp", 64'(rv), 64'd0);
      else begin
        popExp(sel);
        checkOutput({e.tag, "_rsp_err"}, 64'(re), 64'(e.err));
        if (e.cyc >= 0) checkOutput({e.tag, "_rsp_cycle"}, 64'(cyc), 64'(e.cyc));
      end
    end
  endtask

  always @(negedge clk) monitorStep(1'b0);
  always @(negedge clk) monitorStep(1'b1);

  // Drives one request and, at its handshake, queues the writes and response it should cause.
  task automatic applyStimulus(input bit sel, input string tag, input pmp_addr_mode_t mode,
                               input logic [55:0] base, input logic [55:0] size, input logic [3:0] idx,
                               input int n_wr, input logic [3:0] i0, input logic [53:0] a0,
                               input pmp_addr_mode_t m0, input logic [53:0] a1,
                               input bit err, input bit timed);
    int hs;
    exp_t e;
    hs = -1;
    @(posedge clk); #1;
    if (sel) begin
      g_req_valid = 1'b1; g_req_base = base; g_req_size = size; g_req_mode = mode; g_req_idx = idx;
    end else begin
      req_valid = 1'b1; req_base = base; req_size = size; req_mode = mode; req_idx = idx;
    end
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if ((sel ? g_req_ready : req_ready) === 1'b1) begin
        hs = cyc;
        break;
      end
    end
    checkOutput({tag, "_accept"}, 64'(hs >= 0), 64'd1);
    if (hs >= 0) begin
      if (n_wr >= 1) begin
        e = '{tag: {tag, "_w0"}, is_rsp: 1'b0, idx: i0, addr: a0, mode: m0, err: 1'b0,
              cyc: timed ? hs + 2 : -1};
        pushExp(sel, e);
      end
      if (n_wr == 2) begin
        e = '{tag: {tag, "_w1"}, is_rsp: 1'b0, idx: idx, addr: a1, mode: TOR, err: 1'b0,
              cyc: timed ? hs + 3 : -1};
        pushExp(sel, e);
      end
      e = '{tag: tag, is_rsp: 1'b1, idx: '0, addr: '0, mode: '0, err: err,
            cyc: timed ? hs + 2 + n_wr : -1};
      pushExp(sel, e);
    end
    @(posedge clk); #1;
    if (sel) g_req_valid = 1'b0;
    else req_valid = 1'b0;
  endtask

  task automatic waitIdle();
    for (int k = 0; k < 60 && (q0.size() + q1.size()) != 0; k++) @(negedge clk);
    checkOutput("drain", 64'(q0.size() + q1.size()), 64'd0);
    q0.delete();
    q1.delete();
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst_n = 1'b0;
    req_valid = 1'b0; req_base = '0; req_size = '0; req_mode = OFF; req_idx = '0; wr_ready = 1'b1;
    g_req_valid = 1'b0; g_req_base = '0; g_req_size = '0; g_req_mode = OFF; g_req_idx = '0; g_wr_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_req_ready", 64'(req_ready), 64'd1);
    checkOutput("rst_wr_valid", 64'(wr_valid), 64'd0);
    checkOutput("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    checkOutput("rst_rsp_err", 64'(rsp_err), 64'd0);
    checkOutput("rst_wr_idx", 64'(wr_idx), 64'd0);
    checkOutput("rst_wr_addr", 64'(wr_addr), 64'd0);
    checkOutput("rst_wr_mode", 64'(wr_mode), 64'(OFF));
    @(posedge clk); #1;
    rst_n = 1'b1;

    applyStimulus(0, "napot", NAPOT, 56'h8000_0000, 56'h1000, 4'd5, 1, 4'd5, 54'h2000_01FF, NAPOT, '0, 1'b0, 1'b1);
    waitIdle();
    applyStimulus(0, "tor", TOR, 56'h1000, 56'h3000, 4'd3, 2, 4'd2, 54'h400, OFF, 54'h1000, 1'b0, 1'b1);
    waitIdle();
    applyStimulus(0, "na4", NA4, 56'h1004, 56'h4, 4'd0, 1, 4'd0, 54'h401, NA4, '0, 1'b0, 1'b1);
    waitIdle();
    applyStimulus(1, "g1_na4", NA4, 56'h1004, 56'h4, 4'd0, 0, '0, '0, OFF, '0, 1'b1, 1'b1);
    waitIdle();
    applyStimulus(0, "napot_misaligned", NAPOT, 56'h1800, 56'h1000, 4'd5, 0, '0, '0, OFF, '0, 1'b1, 1'b1);
    waitIdle();
    applyStimulus(0, "tor_idx0", TOR, 56'h1000, 56'h3000, 4'd0, 0, '0, '0, OFF, '0, 1'b1, 1'b1);
    waitIdle();
    applyStimulus(0, "napot_npow2", NAPOT, 56'h0, 56'h3000, 4'd5, 0, '0, '0, OFF, '0, 1'b1, 1'b1);
    waitIdle();
    applyStimulus(1, "g1_idx_range", NAPOT, 56'h8000_0000, 56'h1000, 4'd12, 0, '0, '0, OFF, '0, 1'b1, 1'b1);
    waitIdle();
    applyStimulus(0, "off", OFF, 56'h1234, 56'h99, 4'd7, 1, 4'd7, 54'h0, OFF, '0, 1'b0, 1'b1);
    waitIdle();
    applyStimulus(0, "napot_top", NAPOT, 56'h80_0000_0000_0000, 56'h80_0000_0000_0000, 4'd9,
                  1, 4'd9, 54'h2F_FFFF_FFFF_FFFF, NAPOT, '0, 1'b0, 1'b1);
    waitIdle();
    applyStimulus(0, "tor_top", TOR, 56'h1000, 56'hFF_FFFF_FFFF_EFFC, 4'd1,
                  2, 4'd0, 54'h400, OFF, 54'h3F_FFFF_FFFF_FFFF, 1'b0, 1'b1);
    waitIdle();
    applyStimulus(0, "tor_overflow", TOR, 56'h1000, 56'hFF_FFFF_FFFF_F000, 4'd1, 0, '0, '0, OFF, '0, 1'b1, 1'b1);
    waitIdle();

    // Backpressure: 3 stalled cycles in WR0, 2 in WR1.
    wr_ready = 1'b0;
    applyStimulus(0, "tor_bp", TOR, 56'h1000, 56'h3000, 4'd3, 2, 4'd2, 54'h400, OFF, 54'h1000, 1'b0, 1'b0);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkOutput("bp_wr0_valid", 64'(wr_valid), 64'd1);
      checkOutput("bp_wr0_idx", 64'(wr_idx), 64'd2);
      checkOutput("bp_wr0_addr", 64'(wr_addr), 64'h400);
      checkOutput("bp_wr0_mode", 64'(wr_mode), 64'(OFF));
      checkOutput("bp_wr0_req_ready", 64'(req_ready), 64'd0);
      checkOutput("bp_wr0_rsp_valid", 64'(rsp_valid), 64'd0);
    end
    @(posedge clk); #1;
    wr_ready = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    wr_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      checkOutput("bp_wr1_valid", 64'(wr_valid), 64'd1);
      checkOutput("bp_wr1_idx", 64'(wr_idx), 64'd3);
      checkOutput("bp_wr1_addr", 64'(wr_addr), 64'h1000);
      checkOutput("bp_wr1_mode", 64'(wr_mode), 64'(TOR));
      checkOutput("bp_wr1_req_ready", 64'(req_ready), 64'd0);
      checkOutput("bp_wr1_rsp_valid", 64'(rsp_valid), 64'd0);
    end
    @(posedge clk); #1;
    wr_ready = 1'b1;
    waitIdle();

    // Reset while the second TOR write is pending.
    applyStimulus(0, "tor_rst", TOR, 56'h1000, 56'h3000, 4'd3, 2, 4'd2, 54'h400, OFF, 54'h1000, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    @(posedge clk); #1;
    wr_ready = 1'b0;
    @(negedge clk);
    checkOutput("rst_pre_wr1_valid", 64'(wr_valid), 64'd1);
    checkOutput("rst_pre_wr1_mode", 64'(wr_mode), 64'(TOR));
    #1;
    rst_n = 1'b0;
    #1;
    q0.delete();
    checkOutput("rst_mid_wr_valid", 64'(wr_valid), 64'd0);
    checkOutput("rst_mid_req_ready", 64'(req_ready), 64'd1);
    checkOutput("rst_mid_rsp_valid", 64'(rsp_valid), 64'd0);
    checkOutput("rst_mid_wr_mode", 64'(wr_mode), 64'(OFF));
    @(posedge clk); #1;
    rst_n = 1'b1;
    wr_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checkOutput("rst_no_rsp", 64'(rsp_valid), 64'd0);
    end
    applyStimulus(0, "napot_after_rst", NAPOT, 56'h8000_0000, 56'h1000, 4'd5, 1, 4'd5, 54'h2000_01FF, NAPOT, '0, 1'b0, 1'b1);
    waitIdle();

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
